// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle for mem_arbiter.
// The master modport is the arbiter's view; slave is the caches/memory view.
interface mem_arbiter_if #(
    parameter int ARCH_BITS        = 32,
    parameter int MEMORY_LINE_BITS = 128
);
    logic                        iReq;
    logic [ARCH_BITS-1:0]        iAddr;
    logic                        iAck;
    logic [MEMORY_LINE_BITS-1:0] iData;

    logic                        dReq;
    logic                        dWe;
    logic [ARCH_BITS-1:0]        dAddr;
    logic [MEMORY_LINE_BITS-1:0] dWData;
    logic                        dAck;
    logic [MEMORY_LINE_BITS-1:0] dData;

    logic [ARCH_BITS-1:0]        mRAddr;
    logic                        mRE;
    logic [MEMORY_LINE_BITS-1:0] mRData;
    logic                        mRValid;
    logic [ARCH_BITS-1:0]        mWAddr;
    logic                        mWE;
    logic [MEMORY_LINE_BITS-1:0] mWData;
    logic                        mWDone;

    logic                        busy;

    modport master (
        input  iReq, iAddr, dReq, dWe, dAddr, dWData, mRData, mRValid, mWDone,
        output iAck, iData, dAck, dData, mRAddr, mRE, mWAddr, mWE, mWData, busy
    );

    modport slave (
        output iReq, iAddr, dReq, dWe, dAddr, dWData, mRData, mRValid, mWDone,
        input  iAck, iData, dAck, dData, mRAddr, mRE, mWAddr, mWE, mWData, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory read/write channel between the instruction and data caches,
// one transaction at a time, with a one-cycle idle gap after every completion.
//
// state   | meaning
// IDLE    | arbitrate pending requests, latch the winner
// READ    | mRE held with latched address until mRValid
// WRITE   | mWE held with latched address/data until mWDone
// RELEASE | enables low for one cycle, owner's ack pulses
module mem_arbiter #(
    parameter int ARCH_BITS        = 32,
    parameter int MEMORY_LINE_BITS = 128,
    parameter int STARVE_LIMIT     = 4
) (
    input logic            clk,
    input logic            rst,
    mem_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RELEASE} stateType;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    stateType                    state, stateNext;
    logic [3:0]                  starve, starveNext;
    logic                        ownerD, ownerDNext;
    logic [ARCH_BITS-1:0]        addrReg, addrNext;
    logic [MEMORY_LINE_BITS-1:0] wDataReg, wDataNext;
    logic [MEMORY_LINE_BITS-1:0] iDataReg, iDataNext;
    logic [MEMORY_LINE_BITS-1:0] dDataReg, dDataNext;
    logic                        iAckReg, iAckNext;
    logic                        dAckReg, dAckNext;
    logic                        mREReg, mRENext;
    logic                        mWEReg, mWENext;
    logic                        busyReg, busyNext;
    logic                        grantD, grantI;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            starve   <= '0;
            ownerD   <= 1'b0;
            addrReg  <= '0;
            wDataReg <= '0;
            iDataReg <= '0;
            dDataReg <= '0;
            iAckReg  <= 1'b0;
            dAckReg  <= 1'b0;
            mREReg   <= 1'b0;
            mWEReg   <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            state    <= stateNext;
            starve   <= starveNext;
            ownerD   <= ownerDNext;
            addrReg  <= addrNext;
            wDataReg <= wDataNext;
            iDataReg <= iDataNext;
            dDataReg <= dDataNext;
            iAckReg  <= iAckNext;
            dAckReg  <= dAckNext;
            mREReg   <= mRENext;
            mWEReg   <= mWENext;
            busyReg  <= busyNext;
        end
    end

    always_comb begin
        stateNext  = state;
        starveNext = starve;
        ownerDNext = ownerD;
        addrNext   = addrReg;
        wDataNext  = wDataReg;
        iDataNext  = iDataReg;
        dDataNext  = dDataReg;
        iAckNext   = 1'b0;
        dAckNext   = 1'b0;
        grantD     = 1'b0;
        grantI     = 1'b0;

        unique case (state)
            IDLE: begin
                // Data side wins ties until the instruction side has lost LIMIT times in a row
                if (bus.dReq && bus.iReq) begin
                    if (starve == LIMIT) grantI = 1'b1;
                    else                 grantD = 1'b1;
                end else if (bus.dReq) begin
                    grantD = 1'b1;
                end else if (bus.iReq) begin
                    grantI = 1'b1;
                end

                if (grantD) begin
                    ownerDNext = 1'b1;
                    addrNext   = bus.dAddr;
                    wDataNext  = bus.dWData;
                    stateNext  = bus.dWe ? WRITE : READ;
                    if (bus.iReq && starve != LIMIT) starveNext = starve + 4'd1;
                end else if (grantI) begin
                    ownerDNext = 1'b0;
                    addrNext   = bus.iAddr;
                    wDataNext  = bus.dWData;
                    starveNext = '0;
                    stateNext  = READ;
                end
            end
            READ: begin
                if (bus.mRValid) begin
                    if (ownerD) begin
                        dDataNext = bus.mRData;
                        dAckNext  = 1'b1;
                    end else begin
                        iDataNext = bus.mRData;
                        iAckNext  = 1'b1;
                    end
                    stateNext = RELEASE;
                end
            end
            WRITE: begin
                if (bus.mWDone) begin
                    dAckNext  = 1'b1;
                    stateNext = RELEASE;
                end
            end
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        mRENext  = (stateNext == READ);
        mWENext  = (stateNext == WRITE);
        busyNext = (stateNext != IDLE);
    end

    assign bus.iAck   = iAckReg;
    assign bus.iData  = iDataReg;
    assign bus.dAck   = dAckReg;
    assign bus.dData  = dDataReg;
    assign bus.mRAddr = addrReg;
    assign bus.mRE    = mREReg;
    assign bus.mWAddr = addrReg;
    assign bus.mWE    = mWEReg;
    assign bus.mWData = wDataReg;
    assign bus.busy   = busyReg;
endmodule
